// File: rtl/nv_nvdla_pdp_med1d_ctrl_if.sv
// Stream and median-core signal bundle for the PDP 1-D median sequencer.
// The slave modport is the sequencer's view; master is the surrounding logic.
interface nv_nvdla_pdp_med1d_ctrl_if;
  logic        din_pvld;
  logic        din_prdy;
  logic [7:0]  din_pd;
  logic        dout_pvld;
  logic        dout_prdy;
  logic [21:0] dout_pd;
  logic        dout_last;
  logic        core_enable;
  logic [21:0] core_A;
  logic [21:0] core_B;
  logic [21:0] core_med_out;

  modport slave (
    input  din_pvld, din_pd, dout_prdy, core_med_out,
    output din_prdy, dout_pvld, dout_pd, dout_last, core_enable, core_A, core_B
  );

  modport master (
    output din_pvld, din_pd, dout_prdy, core_med_out,
    input  din_prdy, dout_pvld, dout_pd, dout_last, core_enable, core_A, core_B
  );
endinterface

// File: rtl/nv_nvdla_pdp_med1d_ctrl.sv
// Sequencer for the PDP int8 1-D median core: builds sliding windows of 2 or 3
// elements and walks the combinational core through tag / pair-sort / triple-sort.
//
// state | meaning
// IDLE  | waiting for op_en
// LOAD  | accepting elements (drain_q set: consume a too-short line, no output)
// TAG   | core tags the oldest window element
// SORT2 | core sorts the tagged element with the next one
// SORT3 | core LUT merges the third element (kernel 3 only)
// OUT   | result offered on dout
module nv_nvdla_pdp_med1d_ctrl (
  input  logic                     nvdla_core_clk,
  input  logic                     nvdla_core_rstn,
  input  logic                     op_en,
  input  logic [1:0]               cfg_kernel_size,
  input  logic [12:0]              cfg_line_width,
  output logic                     op_busy,
  output logic                     line_done,
  nv_nvdla_pdp_med1d_ctrl_if.slave io
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_TAG   = 3'd2,
    ST_SORT2 = 3'd3,
    ST_SORT3 = 3'd4,
    ST_OUT   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic        k3_q, k3_d;
  logic [12:0] width_q, width_d;
  logic [12:0] in_cnt_q, in_cnt_d;
  logic [1:0]  fill_q, fill_d;
  logic        drain_q, drain_d;
  logic [7:0]  w0_q, w0_d;
  logic [7:0]  w1_q, w1_d;
  logic [7:0]  w2_q, w2_d;
  logic [21:0] res_q, res_d;
  logic        line_done_q, line_done_d;
  logic [1:0]  k_cur;
  logic [12:0] k_cfg;

  function automatic logic [21:0] ext(input logic [7:0] x);
    return {{14{x[7]}}, x};
  endfunction

  always_comb begin
    state_d        = state_q;
    k3_d           = k3_q;
    width_d        = width_q;
    in_cnt_d       = in_cnt_q;
    fill_d         = fill_q;
    drain_d        = drain_q;
    w0_d           = w0_q;
    w1_d           = w1_q;
    w2_d           = w2_q;
    res_d          = res_q;
    line_done_d    = 1'b0;
    k_cur          = k3_q ? 2'd3 : 2'd2;
    k_cfg          = (cfg_kernel_size == 2'd2) ? 13'd2 : 13'd3;
    io.din_prdy    = 1'b0;
    io.dout_pvld   = 1'b0;
    io.dout_pd     = '0;
    io.dout_last   = 1'b0;
    io.core_enable = 1'b0;
    io.core_A      = '0;
    io.core_B      = '0;

    case (state_q)
      ST_IDLE: begin
        if (op_en) begin
          k3_d     = (cfg_kernel_size != 2'd2);
          width_d  = cfg_line_width;
          in_cnt_d = '0;
          fill_d   = '0;
          drain_d  = (cfg_line_width < k_cfg);
          // An empty line completes immediately without leaving IDLE.
          if (cfg_line_width == 13'd0) begin
            line_done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        io.din_prdy = 1'b1;
        if (io.din_pvld) begin
          w0_d     = w1_q;
          w1_d     = w2_q;
          w2_d     = io.din_pd;
          in_cnt_d = in_cnt_q + 13'd1;
          if (drain_q) begin
            if (in_cnt_d == width_q) begin
              line_done_d = 1'b1;
              drain_d     = 1'b0;
              state_d     = ST_IDLE;
            end
          end else begin
            // fill saturates at K, so after the first window every element completes one.
            if (fill_q < k_cur) begin
              fill_d = fill_q + 2'd1;
            end
            if (fill_q >= k_cur - 2'd1) begin
              state_d = ST_TAG;
            end
          end
        end
      end

      ST_TAG: begin
        io.core_A = k3_q ? ext(w0_q) : ext(w1_q);
        res_d     = io.core_med_out;
        state_d   = ST_SORT2;
      end

      ST_SORT2: begin
        io.core_A = res_q;
        io.core_B = k3_q ? ext(w1_q) : ext(w2_q);
        res_d     = io.core_med_out;
        state_d   = k3_q ? ST_SORT3 : ST_OUT;
      end

      ST_SORT3: begin
        io.core_A      = res_q;
        io.core_B      = ext(w2_q);
        io.core_enable = 1'b1;
        res_d          = io.core_med_out;
        state_d        = ST_OUT;
      end

      ST_OUT: begin
        io.dout_pvld = 1'b1;
        io.dout_pd   = res_q;
        io.dout_last = (in_cnt_q == width_q);
        if (io.dout_prdy) begin
          if (in_cnt_q == width_q) begin
            line_done_d = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      state_q     <= ST_IDLE;
      k3_q        <= 1'b0;
      width_q     <= '0;
      in_cnt_q    <= '0;
      fill_q      <= '0;
      drain_q     <= 1'b0;
      w0_q        <= '0;
      w1_q        <= '0;
      w2_q        <= '0;
      res_q       <= '0;
      line_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k3_q        <= k3_d;
      width_q     <= width_d;
      in_cnt_q    <= in_cnt_d;
      fill_q      <= fill_d;
      drain_q     <= drain_d;
      w0_q        <= w0_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      res_q       <= res_d;
      line_done_q <= line_done_d;
    end
  end

  assign op_busy   = (state_q != ST_IDLE);
  assign line_done = line_done_q;

endmodule

// File: tb/tb_nv_nvdla_pdp_med1d_ctrl.sv
// Directed bench for the PDP 1-D median sequencer: a stand-in median core, a
// window-level reference model and a per-cycle output checker.
module tb_nv_nvdla_pdp_med1d_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        op_en = 1'b0;
  logic [1:0]  cfg_k = 2'd3;
  logic [12:0] cfg_w = '0;
  logic        op_busy;
  logic        line_done;

  int checks = 0;
  int errors = 0;
  int ld_cnt = 0;
  int en_cnt = 0;

  logic [22:0] exp_q[$];
  logic [22:0] got_q[$];
  logic [44:0] op_log[$];
  int          line_el[$];

  logic        prev_hold = 1'b0;
  logic [21:0] prev_pd = '0;
  logic        prev_last = 1'b0;

  int t2_med[3] = '{4, 4, 0};
  int t2_last[3] = '{0, 0, 1};
  logic [15:0] t3_pair[3] = '{16'hFF03, 16'h0303, 16'h0308};

  nv_nvdla_pdp_med1d_ctrl_if io();

  nv_nvdla_pdp_med1d_ctrl dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .op_en           (op_en),
    .cfg_kernel_size (cfg_k),
    .cfg_line_width  (cfg_w),
    .op_busy         (op_busy),
    .line_done       (line_done),
    .io              (io)
  );

  always #5 clk = ~clk;

  // Stand-in median core: low 5 bits of min/median/max plus a sign-derived LUT code.
  function automatic logic [21:0] pack3(input logic [7:0] mn, input logic [7:0] md, input logic [7:0] mx);
    return {mx[7], md[7], mn[7], 4'b0101, mn[4:0], md[4:0], mx[4:0]};
  endfunction

  function automatic logic [21:0] core_stub(input logic [21:0] a, input logic [21:0] b, input logic en);
    logic signed [7:0] lo, hi, z;
    if (en) begin
      lo = a[15:8];
      hi = a[7:0];
      z  = b[7:0];
      if (z < lo) return pack3(z, lo, hi);
      if (z > hi) return pack3(lo, hi, z);
      return pack3(lo, z, hi);
    end
    if (a[21:20] == 2'b10) begin
      lo = a[7:0];
      z  = b[7:0];
      if (z < lo) return {2'b11, 4'b0000, z, lo};
      return {2'b11, 4'b0000, lo, z};
    end
    return {2'b10, 12'b0, a[7:0]};
  endfunction

  always_comb io.core_med_out = core_stub(io.core_A, io.core_B, io.core_enable);

  // Reference: the result a whole window must produce, from plain sorting.
  function automatic logic [21:0] model_word(input int k, input int a, input int b, input int c);
    int s0, s1, s2, t;
    if (k == 2) begin
      s0 = (a < b) ? a : b;
      s1 = (a < b) ? b : a;
      return {2'b11, 4'b0000, 8'(s0), 8'(s1)};
    end
    s0 = a; s1 = b; s2 = c;
    if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
    if (s1 > s2) begin t = s1; s1 = s2; s2 = t; end
    if (s0 > s1) begin t = s0; s0 = s1; s1 = t; end
    return pack3(8'(s0), 8'(s1), 8'(s2));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (line_done) ld_cnt++;
    if (io.core_enable) en_cnt++;
    if (io.core_enable || io.core_A != 22'd0 || io.core_B != 22'd0)
      op_log.push_back({io.core_enable, io.core_A, io.core_B});
  end

  // Output checker: every transfer against the model, plus hold and din_prdy rules.
  always @(negedge clk) begin
    logic [22:0] e;
    if (!rstn) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        checks++;
        if (io.dout_pvld !== 1'b1 || io.dout_pd !== prev_pd || io.dout_last !== prev_last) begin
          errors++;
          $display("FAIL hold_stable actual=%0h/%0h/%0h required=1/%0h/%0h",
                   io.dout_pvld, io.dout_pd, io.dout_last, prev_pd, prev_last);
        end
      end
      if (io.dout_pvld) begin
        checks++;
        if (io.din_prdy !== 1'b0) begin
          errors++;
          $display("FAIL din_prdy_during_out actual=%0h required=0", io.din_prdy);
        end
      end
      if (io.dout_pvld && io.dout_prdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%0h required=none", {io.dout_last, io.dout_pd});
        end else begin
          e = exp_q.pop_front();
          if ({io.dout_last, io.dout_pd} !== e) begin
            errors++;
            $display("FAIL dout_word actual=%0h required=%0h", {io.dout_last, io.dout_pd}, e);
          end
        end
        got_q.push_back({io.dout_last, io.dout_pd});
      end
      prev_hold = io.dout_pvld && !io.dout_prdy;
      prev_pd   = io.dout_pd;
      prev_last = io.dout_last;
    end
  end

  task automatic pulse_op(input int k, input int w);
    @(posedge clk); #1;
    op_en = 1'b1;
    cfg_k = 2'(k);
    cfg_w = 13'(w);
    @(posedge clk); #1;
    op_en = 1'b0;
  endtask

  task automatic feed(input int v);
    int n;
    n = 0;
    io.din_pvld = 1'b1;
    io.din_pd   = 8'(v);
    forever begin
      @(negedge clk);
      if (io.din_prdy) break;
      n++;
      if (n > 300) begin
        chk("feed_timeout", 64'(n), 64'd0);
        break;
      end
    end
    @(posedge clk); #1;
    io.din_pvld = 1'b0;
  endtask

  task automatic wait_pvld();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (io.dout_pvld) break;
      n++;
      if (n > 300) begin
        chk("pvld_timeout", 64'(n), 64'd0);
        break;
      end
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (line_done) break;
      n++;
      if (n > 500) begin
        chk("line_done_timeout", 64'(n), 64'd0);
        break;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_flags"}, 64'({io.din_prdy, io.dout_pvld, io.dout_last, io.core_enable, op_busy, line_done}), 64'd0);
    chk({tag, "_dout_pd"}, 64'(io.dout_pd), 64'd0);
    chk({tag, "_core_ab"}, 64'({io.core_A, io.core_B}), 64'd0);
  endtask

  task automatic run_line(input int k, input int w, input bit stall, input bit poke);
    int kk, base_ld, c;
    kk = (k == 2) ? 2 : 3;
    got_q.delete();
    op_log.delete();
    en_cnt = 0;
    if (w >= kk) begin
      for (int i = 0; i <= w - kk; i++) begin
        c = 0;
        if (kk == 3) c = line_el[i+2];
        exp_q.push_back({(i == w - kk), model_word(kk, line_el[i], line_el[i+1], c)});
      end
    end
    base_ld = ld_cnt;
    if (stall) io.dout_prdy = 1'b0;
    pulse_op(k, w);
    fork
      begin
        for (int i = 0; i < w; i++) begin
          feed(line_el[i]);
          if (poke && i == 0) begin
            op_en = 1'b1;
            cfg_k = 2'd2;
            cfg_w = 13'd1;
            @(posedge clk); #1;
            op_en = 1'b0;
          end
        end
      end
      begin
        if (stall) begin
          wait_pvld();
          repeat (10) @(posedge clk);
          #1 io.dout_prdy = 1'b1;
        end
      end
    join
    wait_done();
    repeat (3) @(negedge clk);
    chk("line_done_pulses", 64'(ld_cnt - base_ld), 64'd1);
    chk("outputs_outstanding", 64'(exp_q.size()), 64'd0);
    chk("idle_after_line", 64'(op_busy), 64'd0);
  endtask

  initial begin
    io.din_pvld  = 1'b0;
    io.din_pd    = '0;
    io.dout_prdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check_all_zero("reset");

    // Kernel 3, width 3: single window, operands and packed result pinned by hand.
    line_el = '{5, -3, 2};
    run_line(3, 3, 1'b0, 1'b0);
    chk("t1_op_count", 64'(op_log.size()), 64'd3);
    if (op_log.size() == 3) begin
      chk("t1_tag_a", 64'(op_log[0][43:22]), 64'h000005);
      chk("t1_tag_b", 64'(op_log[0][21:0]), 64'h0);
      chk("t1_sort2_b", 64'(op_log[1][21:0]), 64'h3FFFFD);
      chk("t1_sort3_b", 64'(op_log[2][21:0]), 64'h000002);
      chk("t1_sort3_en", 64'(op_log[2][44]), 64'd1);
    end
    chk("t1_out_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) begin
      chk("t1_result", 64'(got_q[0][14:0]), 64'h7445);
      chk("t1_last", 64'(got_q[0][22]), 64'd1);
    end

    // Kernel 3, width 5: three sliding windows.
    line_el = '{1, 9, 4, 0, -7};
    run_line(3, 5, 1'b0, 1'b0);
    chk("t2_out_count", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t2_median%0d", i), 64'(got_q[i][9:5]), 64'(t2_med[i]));
        chk($sformatf("t2_last%0d", i), 64'(got_q[i][22]), 64'(t2_last[i]));
      end
    end

    // Kernel 2, width 4: pair mode, LUT never enabled.
    line_el = '{-1, 3, 3, 8};
    run_line(2, 4, 1'b0, 1'b0);
    chk("t3_out_count", 64'(got_q.size()), 64'd3);
    chk("t3_core_enable_cycles", 64'(en_cnt), 64'd0);
    if (got_q.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("t3_pair%0d", i), 64'(got_q[i][15:0]), 64'(t3_pair[i]));
        chk($sformatf("t3_prefix%0d", i), 64'(got_q[i][21:20]), 64'd3);
      end
    end

    // Kernel 2, width 2: exactly one window.
    line_el = '{4, -4};
    run_line(2, 2, 1'b0, 1'b0);
    if (got_q.size() == 1) chk("t4_pair", 64'(got_q[0][15:0]), 64'hFC04);

    // Backpressure on the first result of a kernel-3 line.
    line_el = '{10, -20, 30, 7};
    run_line(3, 4, 1'b1, 1'b0);
    chk("t5_out_count", 64'(got_q.size()), 64'd2);

    // Kernel-size code other than 2 selects kernel 3.
    line_el = '{-5, 100, -50};
    run_line(1, 3, 1'b0, 1'b0);
    if (got_q.size() == 1) chk("t6_median", 64'(got_q[0][9:5]), 64'h1B);

    // Lines shorter than the kernel are drained without output.
    line_el = '{7, 8};
    run_line(3, 2, 1'b0, 1'b0);
    chk("t7_no_output", 64'(got_q.size()), 64'd0);
    line_el = '{-9};
    run_line(2, 1, 1'b0, 1'b0);
    chk("t8_no_output", 64'(got_q.size()), 64'd0);

    // Width 0 completes the cycle after op_en.
    pulse_op(3, 0);
    @(negedge clk);
    chk("t9_line_done_now", 64'(line_done), 64'd1);
    @(negedge clk);
    chk("t9_line_done_drop", 64'(line_done), 64'd0);

    // Reset during SORT2 discards the line.
    line_el = '{1, 2, 3};
    pulse_op(3, 3);
    for (int i = 0; i < 3; i++) feed(line_el[i]);
    begin
      int n;
      n = 0;
      forever begin
        @(negedge clk);
        if (io.core_A[21:20] == 2'b10) break;
        n++;
        if (n > 50) begin
          chk("sort2_timeout", 64'(n), 64'd0);
          break;
        end
      end
    end
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    begin
      int base;
      base = ld_cnt;
      repeat (8) @(negedge clk);
      chk("mid_reset_no_done", 64'(ld_cnt - base), 64'd0);
    end

    // Fresh line after reset, with op_en and config changes poked while busy.
    line_el = '{-128, 127, 0, -1};
    run_line(3, 4, 1'b0, 1'b1);
    chk("t10_out_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk("t10_median0", 64'(got_q[0][9:5]), 64'd0);
      chk("t10_median1", 64'(got_q[1][9:5]), 64'd0);
      chk("t10_min1", 64'(got_q[1][14:10]), 64'h1F);
    end

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
